data_mem_responder: RTL



---
 rtl/data_mem_responder_if.sv | 32 +++
 rtl/data_mem_responder.sv | 103 ++++++++++
 2 files changed

// File: rtl/data_mem_responder_if.sv
// MEM-stage data-memory request/response bundle for data_mem_responder.
// err exists only when MEM_ERR_CHECK_EN is defined.
interface data_mem_responder_if #(
  parameter int unsigned WORD_LEN = 32
);
  logic                MEM_R_EN;
  logic                MEM_W_EN;
  logic [WORD_LEN-1:0] addr;
  logic [WORD_LEN-1:0] ST_value;
  logic [WORD_LEN-1:0] rd_data;
  logic                ready;
  logic                stall;
`ifdef MEM_ERR_CHECK_EN
  logic                err;
`endif

  modport master (
    output MEM_R_EN, MEM_W_EN, addr, ST_value,
    input  rd_data, ready, stall
`ifdef MEM_ERR_CHECK_EN
    , err
`endif
  );

  modport slave (
    input  MEM_R_EN, MEM_W_EN, addr, ST_value,
    output rd_data, ready, stall
`ifdef MEM_ERR_CHECK_EN
    , err
`endif
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data RAM responder with programmable wait states and pipeline stall.
// Optional address checking (err output, suppressed access) with MEM_ERR_CHECK_EN.
module data_mem_responder #(
  parameter int unsigned WORD_LEN    = 32,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  data_mem_responder_if.slave bus
);
  localparam int unsigned         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WORD_LEN-1:0] BASE      = WORD_LEN'(BASE_ADDR);
  localparam logic [3:0]          WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              r_state, w_next;
  logic [3:0]          r_cnt;
  logic                r_is_st;
  logic [IDX_W-1:0]    r_idx;
  logic [WORD_LEN-1:0] r_st_val;
  logic [WORD_LEN-1:0] r_rd_data;
  logic [WORD_LEN-1:0] r_mem [DEPTH];

  logic                w_req;
  logic                w_fire;
  logic                w_ok;
  logic [WORD_LEN-1:0] w_off;
  logic [IDX_W-1:0]    w_idx;

  assign w_req  = bus.MEM_R_EN | bus.MEM_W_EN;
  assign w_off  = bus.addr - BASE;
  assign w_idx  = IDX_W'(w_off >> 2);
  assign w_fire = (r_state == BUSY) && (r_cnt == '0);

`ifdef MEM_ERR_CHECK_EN
  localparam logic [WORD_LEN-1:0] LIMIT = WORD_LEN'(BASE_ADDR + 4 * DEPTH);

  logic r_err_op;
  logic r_err;
  logic w_addr_bad;

  assign w_addr_bad = (bus.addr < BASE) || (bus.addr >= LIMIT) || (bus.addr[1:0] != 2'b00);
  assign w_ok       = ~r_err_op;
  assign bus.err    = r_err;

  // Flag is raised on the completing edge so it appears alongside ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_op <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == IDLE && w_req) r_err_op <= w_addr_bad;
      if (w_fire && r_err_op)       r_err    <= 1'b1;
    end
  end
`else
  assign w_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_is_st   <= 1'b0;
      r_idx     <= '0;
      r_st_val  <= '0;
      r_rd_data <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_req) begin
        r_is_st  <= bus.MEM_W_EN;
        r_idx    <= w_idx;
        r_st_val <= bus.ST_value;
        r_cnt    <= WAIT_INIT;
      end else if (r_state == BUSY && r_cnt != '0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_fire && !r_is_st && w_ok) r_rd_data <= r_mem[r_idx];
    end
  end

  // RAM is not reset; a store pending when rst arrives is dropped.
  always_ff @(posedge clk) begin
    if (!rst && w_fire && r_is_st && w_ok) r_mem[r_idx] <= r_st_val;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_req) w_next = BUSY;
      BUSY:    if (r_cnt == '0) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign bus.stall   = w_req && (r_state != DONE);
  assign bus.ready   = (r_state == DONE);
  assign bus.rd_data = r_rd_data;
endmodule
